lsu_seq_ctrl: RTL
=================

# lsu_seq_ctrl

Sequencer between the load/store unit and the data-memory port. Accepts one load or store request at a time and runs the req/gnt/rvalid handshake on the data bus. Splits misaligned accesses into two aligned word transactions, then merges, aligns and sign/zero-extends read data. Returns a single completion pulse with registered data and error to the downstream result-capture stage.

## Interface
- AddrWidth, 32, byte-address width; must be ≥ 3.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- lsu_req_i  in  1  request valid; sampled only when lsu_busy_o = 0.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_type_i  in  2  access size: 00 word, 01 half, 10 byte; 11 is reserved and treated as a word.
- lsu_sign_ext_i  in  1  sign-extend load data (half/byte only).
- lsu_addr_i  in  AddrWidth  byte address.
- lsu_wdata_i  in  32  store data, LSB-aligned.
- lsu_busy_o  out  1  transaction in flight; combinational from state.
- lsu_rvalid_o  out  1  one-cycle completion pulse, registered.
- lsu_rdata_o  out  32  aligned and extended load data, registered.
- lsu_err_o  out  1  error for the completing access, registered; valid with lsu_rvalid_o.
- data_req_o  out  1  bus request.
- data_gnt_i  in  1  bus grant.
- data_rvalid_i  in  1  bus response valid.
- data_we_o  out  1  bus write enable.
- data_be_o  out  4  byte enables.
- data_addr_o  out  AddrWidth  word-aligned bus address (bits [1:0] = 0).
- data_wdata_o  out  32  store data rotated into byte lanes.
- data_rdata_i  in  32  bus read data.
- data_err_i  in  1  bus error, qualified by data_rvalid_i.

## Operation
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1. lsu_busy_o = (state != IDLE).
- IDLE with lsu_req_i = 1: register we, type, sign_ext, addr and wdata, then go to REQ0. Requests arriving while busy are ignored; the requester holds lsu_req_i until it is accepted.
- REQ0 and REQ1: data_req_o = 1, with addr/be/we/wdata held stable until data_gnt_i. On grant, go to WAIT0 or WAIT1 respectively; data_req_o is 0 in the WAIT states.
- WAIT0 and WAIT1: wait for data_rvalid_i. data_rvalid_i is ignored in every other state.
- Misaligned access is a word at offset ≠ 0, or a half at offset 3 (offset = addr[1:0]).
- First beat: address {addr[AddrWidth-1:2],00}.
  - Word: be = 1111 << off.
  - Half: be = 0011 << off.
  - Byte: be = 0001 << off.
  - All are truncated to 4 bits.
- Second beat: address = first + 4, wrapping modulo 2^AddrWidth (0x...FFC → 0x000). be = bits of the full 8-bit mask above 4. Examples: word off 1 → 0001; half off 3 → 0001.
- Store data on both beats: lsu_wdata_i rotated left by 8·off.
- Read merge:
  - merged = (rdata0 >> 8·off) | (rdata1 << 8·(4−off)); the second term is present only when split.
  - Byte result is merged[7:0], half result is merged[15:0], word result is merged.
  - Half and byte are zero- or sign-extended per sign_ext.
- Completion is taken on data_rvalid_i in WAIT0 when not split, or in WAIT1.
  - Load: lsu_rdata_o ← result, lsu_err_o ← data_err_i.
  - Store: lsu_rdata_o ← 0.
  - Next state is IDLE.
- Error in WAIT0 on a split access: skip REQ1, complete immediately with lsu_err_o = 1 and lsu_rdata_o = 0.
- lsu_rdata_o and lsu_err_o hold their values between completions.

## Timing
- Reset values: lsu_rvalid_o = 0, lsu_rdata_o = 0, lsu_err_o = 0, state = IDLE. Hence data_req_o = 0, data_be_o = 0 and lsu_busy_o = 0.
- Reset mid-transaction forces IDLE at that edge and drops data_req_o the following cycle. A late data_rvalid_i is then ignored; the bus master guarantees quiescence before asserting reset.
- Aligned latency with zero-wait gnt and rvalid: accept at edge 0, REQ0 in cycle 1, WAIT0 with rvalid in cycle 2, lsu_rvalid_o high in cycle 3.
- Split latency: lsu_rvalid_o high in cycle 5.
- Each gnt wait cycle and each rvalid wait cycle adds exactly 1 cycle.
- data_rvalid_i may arrive no earlier than the cycle after data_gnt_i.
- A new request is accepted in the same cycle lsu_rvalid_o pulses (state is already IDLE).

## Configuration
- LSU_SEQ_MISALIGNED_EN defined: misaligned accesses are split into two beats as described.
- Undefined:
  - A misaligned request is accepted, no bus transaction is issued, and the FSM returns from REQ0 to IDLE without asserting data_req_o.
  - lsu_rvalid_o and lsu_err_o pulse 2 cycles after acceptance, with lsu_rdata_o = 0.
  - REQ1 and WAIT1 are not synthesized.

## Structure
- Package lsu_seq_pkg: lsu_type_e (WORD, HALF, BYTE), lsu_seq_state_e, and constants for the offset-to-byte-enable masks.
- Sub-module lsu_seq_align (combinational): be/wdata rotation, the split detect, and read merge plus extension. The FSM and registers stay in lsu_seq_ctrl.

## Test plan
- Aligned word load at 0x100, rdata 0xDEADBEEF, gnt and rvalid immediate → one bus beat with be 1111, then lsu_rvalid_o in cycle 3 with lsu_rdata_o 0xDEADBEEF.
- Signed byte load at 0x103, rdata 0x80xxxxxx → be 1000, lsu_rdata_o 0xFFFFFF80. With sign_ext = 0 → 0x00000080.
- Misaligned word store at 0x0FE, wdata 0x11223344 → beats to 0x0FC (be 1100, wdata 0x33441122) then 0x100 (be 0011, same wdata); lsu_rvalid_o in cycle 5.
- Misaligned half load at 0xFFFFFFFF → beats to 0xFFFFFFFC (be 1000) then 0x00000000 (be 0001), with the merge checked.
- Split load where beat 0 returns data_err_i = 1 → no second data_req_o, lsu_err_o = 1, lsu_rdata_o = 0.
- Reset asserted in WAIT0 with gnt delayed 3 cycles → IDLE, data_req_o low the next cycle, and the late rvalid produces no lsu_rvalid_o.

Source files
------------

// File: rtl/lsu_seq_pkg.sv
// Shared types and byte-enable constants for the LSU bus sequencer.
package lsu_seq_pkg;

  typedef enum logic [1:0] {
    WORD = 2'b00,
    HALF = 2'b01,
    BYTE = 2'b10
  } lsu_type_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1
  } lsu_seq_state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;

  // Reserved type encoding 2'b11 falls through to a full word.
  function automatic logic [3:0] base_be(input logic [1:0] acc_type);
    case (acc_type)
      HALF:    return BE_HALF;
      BYTE:    return BE_BYTE;
      default: return BE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_seq_align.sv
// Combinational lane logic: byte enables, store rotation, split detect,
// and read-data merge with zero/sign extension.
module lsu_seq_align
  import lsu_seq_pkg::*;
(
  input  logic [1:0]  acc_type,
  input  logic [1:0]  off,
  input  logic        beat,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic        split,
  output logic [3:0]  be,
  output logic [31:0] wdata_rot,
  output logic [31:0] rdata_ext
);

  logic [4:0]  sh;
  logic [7:0]  mask8;
  logic [31:0] merged;

  // NOTE: combinational logic uses blocking assignments; each output gets a
  // value on every path so no latch is inferred.
  always_comb begin
    sh    = {off, 3'b000};
    mask8 = {4'b0000, base_be(acc_type)} << off;
    be    = beat ? mask8[7:4] : mask8[3:0];

    if (acc_type == HALF) split = (off == 2'd3);
    else                  split = (acc_type != BYTE) && (off != 2'd0);

    wdata_rot = (wdata << sh) | (wdata >> (6'd32 - {1'b0, sh}));

    merged = rdata_lo >> sh;
    if (split) merged = merged | (rdata_hi << (6'd32 - {1'b0, sh}));

    case (acc_type)
      BYTE:    rdata_ext = {{24{sign_ext & merged[7]}}, merged[7:0]};
      HALF:    rdata_ext = {{16{sign_ext & merged[15]}}, merged[15:0]};
      default: rdata_ext = merged;
    endcase
  end

endmodule

// File: rtl/lsu_seq_ctrl.sv
// LSU-to-data-memory sequencer. Define LSU_SEQ_MISALIGNED_EN to split
// misaligned accesses into two beats; otherwise they complete with an error.
module lsu_seq_ctrl
  import lsu_seq_pkg::*;
#(
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lsu_req_i,
  input  logic                 lsu_we_i,
  input  logic [1:0]           lsu_type_i,
  input  logic                 lsu_sign_ext_i,
  input  logic [AddrWidth-1:0] lsu_addr_i,
  input  logic [31:0]          lsu_wdata_i,
  output logic                 lsu_busy_o,
  output logic                 lsu_rvalid_o,
  output logic [31:0]          lsu_rdata_o,
  output logic                 lsu_err_o,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [AddrWidth-1:0] data_addr_o,
  output logic [31:0]          data_wdata_o,
  input  logic [31:0]          data_rdata_i,
  input  logic                 data_err_i
);

  lsu_seq_state_e state_q, state_d;

  logic                 we_q;
  logic [1:0]           type_q;
  logic                 sext_q;
  logic [AddrWidth-1:0] addr_q;
  logic [31:0]          wdata_q;

  logic        complete, cmp_err, cmp_zero;
  logic        split, beat;
  logic [3:0]  be;
  logic [31:0] wdata_rot, rdata_lo, rdata_ext;

`ifdef LSU_SEQ_MISALIGNED_EN
  logic [31:0] rdata0_q;
  logic        save_lo;
  assign rdata_lo = (state_q == WAIT1) ? rdata0_q : data_rdata_i;
`else
  assign rdata_lo = data_rdata_i;
`endif

  assign beat = (state_q == REQ1);

  lsu_seq_align u_align (
    .acc_type  (type_q),
    .off       (addr_q[1:0]),
    .beat      (beat),
    .sign_ext  (sext_q),
    .wdata     (wdata_q),
    .rdata_lo  (rdata_lo),
    .rdata_hi  (data_rdata_i),
    .split     (split),
    .be        (be),
    .wdata_rot (wdata_rot),
    .rdata_ext (rdata_ext)
  );

  assign lsu_busy_o   = (state_q != IDLE);
  assign data_we_o    = data_req_o & we_q;
  assign data_be_o    = data_req_o ? be : 4'b0000;
  assign data_wdata_o = wdata_rot;
  assign data_addr_o  = beat ? {addr_q[AddrWidth-1:2] + (AddrWidth-2)'(1), 2'b00}
                             : {addr_q[AddrWidth-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    data_req_o = 1'b0;
    complete   = 1'b0;
    cmp_err    = 1'b0;
    cmp_zero   = 1'b0;
`ifdef LSU_SEQ_MISALIGNED_EN
    save_lo    = 1'b0;
`endif
    case (state_q)
      IDLE: if (lsu_req_i) state_d = REQ0;
      REQ0: begin
`ifdef LSU_SEQ_MISALIGNED_EN
        data_req_o = 1'b1;
        if (data_gnt_i) state_d = WAIT0;
`else
        if (split) begin
          state_d  = IDLE;
          complete = 1'b1;
          cmp_err  = 1'b1;
          cmp_zero = 1'b1;
        end else begin
          data_req_o = 1'b1;
          if (data_gnt_i) state_d = WAIT0;
        end
`endif
      end
      WAIT0: if (data_rvalid_i) begin
        state_d  = IDLE;
        complete = 1'b1;
        cmp_err  = data_err_i;
        cmp_zero = we_q;
`ifdef LSU_SEQ_MISALIGNED_EN
        // A faulting first beat ends the access without issuing the second.
        if (split) begin
          if (data_err_i) begin
            cmp_zero = 1'b1;
          end else begin
            complete = 1'b0;
            save_lo  = 1'b1;
            state_d  = REQ1;
          end
        end
`endif
      end
`ifdef LSU_SEQ_MISALIGNED_EN
      REQ1: begin
        data_req_o = 1'b1;
        if (data_gnt_i) state_d = WAIT1;
      end
      WAIT1: if (data_rvalid_i) begin
        state_d  = IDLE;
        complete = 1'b1;
        cmp_err  = data_err_i;
        cmp_zero = we_q;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      lsu_rvalid_o <= 1'b0;
      lsu_rdata_o  <= 32'h0;
      lsu_err_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lsu_rvalid_o <= complete;
      if (complete) begin
        lsu_rdata_o <= cmp_zero ? 32'h0 : rdata_ext;
        lsu_err_o   <= cmp_err;
      end
    end
  end

  // NOTE: request and first-beat registers carry no reset; they are only
  // consumed while the FSM is out of IDLE, after they have been loaded.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && lsu_req_i) begin
      we_q    <= lsu_we_i;
      type_q  <= lsu_type_i;
      sext_q  <= lsu_sign_ext_i;
      addr_q  <= lsu_addr_i;
      wdata_q <= lsu_wdata_i;
    end
`ifdef LSU_SEQ_MISALIGNED_EN
    if (save_lo) rdata0_q <= data_rdata_i;
`endif
  end

endmodule
